apb_req_issuer: RTL and testbench

- Upstream command stage for the two-slave APB bridge.
- Accepts host read/write requests over valid/ready and buffers them in a small FIFO.
- Drives the bridge's user-side controls (transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr) one command at a time.
- Snoops bus penable/pready for completion, captures apb_read_data_out, and returns a one-cycle response to the host.

---
 rtl/apb_req_issuer.sv | 152 +++++++++++++++
 tb/tb_apb_req_issuer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_issuer.sv
// apb_req_issuer: host command FIFO feeding the two-slave APB bridge user side, one command at a time
// Ports: pclk/preset (async, active-high) clock and reset;
//   req_valid/req_ready/req_write/req_addr/req_wdata host request channel;
//   rsp_valid/rsp_write/rsp_rdata/rsp_err one-cycle host response;
//   transfer/read_write/apb_write_paddr/apb_write_data/apb_read_paddr registered bridge controls;
//   apb_read_data_out bridge read data; penable/pready snooped APB bus for completion.
// Optional: define APB_ISSUE_TIMEOUT_EN to abort a command after TIMEOUT WAIT cycles (rsp_err=1).
module apb_req_issuer #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          transfer,
    output logic          read_write,
    output logic [AW-1:0] apb_write_paddr,
    output logic [DW-1:0] apb_write_data,
    output logic [AW-1:0] apb_read_paddr,
    input  logic [DW-1:0] apb_read_data_out,
    input  logic          penable,
    input  logic          pready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT);
    localparam logic [CW-1:0] RD_LAST = CW'(1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RDCAP, RESP} state_t;
    state_t          state;
    logic [DEPTH-1:0] q_write;
    logic [AW-1:0]   q_addr [DEPTH];
    logic [DW-1:0]   q_wdata [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [CW-1:0]   rd_cnt;
    logic            cur_write;
    logic            push, pop, done, tmo, head_write;
    assign req_ready  = !preset && count != FULL;
    assign push       = req_valid && req_ready;
    assign done       = penable && pready;
    assign pop        = state == WAIT && (done || tmo);
    assign head_write = q_write[rd_ptr];
`ifdef APB_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wait_cnt;
    assign tmo = state == WAIT && !done && wait_cnt == T_LAST;
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= state == WAIT ? wait_cnt + TW'(1) : '0;
            if (pop) rsp_err <= tmo;
        end
    end
`else
    assign tmo = 1'b0;
    // constant 0 for any legal TIMEOUT; keeps the parameter referenced with the watchdog compiled out
    assign rsp_err = TIMEOUT < 0;
`endif
    // storage needs no reset: only entries below count are ever read
    always_ff @(posedge pclk) begin
        if (push) begin
            q_write[wr_ptr] <= req_write;
            q_addr[wr_ptr]  <= req_addr;
            q_wdata[wr_ptr] <= req_wdata;
        end
    end
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state           <= IDLE;
            transfer        <= 1'b0;
            read_write      <= 1'b0;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
            apb_read_paddr  <= '0;
            rsp_valid       <= 1'b0;
            rsp_write       <= 1'b0;
            rsp_rdata       <= '0;
            rd_cnt          <= '0;
            cur_write       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (count != '0) begin
                    transfer        <= 1'b1;
                    read_write      <= !head_write;
                    cur_write       <= head_write;
                    apb_write_paddr <= head_write ? q_addr[rd_ptr] : '0;
                    apb_write_data  <= head_write ? q_wdata[rd_ptr] : '0;
                    apb_read_paddr  <= head_write ? '0 : q_addr[rd_ptr];
                    state           <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (pop) begin
                    transfer        <= 1'b0;
                    read_write      <= 1'b0;
                    apb_write_paddr <= '0;
                    apb_write_data  <= '0;
                    apb_read_paddr  <= '0;
                    rsp_write       <= cur_write;
                    // writes and aborted commands answer next cycle; reads wait for bridge read data
                    if (cur_write || tmo) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        rd_cnt <= RD_LOAD;
                        state  <= RDCAP;
                    end
                end
                RDCAP: begin
                    rd_cnt <= rd_cnt - CW'(1);
                    // data becomes valid RD_LAT cycles after completion; latch it on the last count
                    if (rd_cnt == RD_LAST) begin
                        rsp_rdata <= apb_read_data_out;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_issuer.sv
// tb_apb_req_issuer: directed self-checking bench for apb_req_issuer
module tb_apb_req_issuer;
    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [8:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid, rsp_write, rsp_err;
    logic [7:0] rsp_rdata;
    logic       transfer, read_write;
    logic [8:0] apb_write_paddr, apb_read_paddr;
    logic [7:0] apb_write_data;
    logic [7:0] apb_read_data_out = '0;
    logic       penable = 1'b0, pready = 1'b0;
    int         n_chk = 0, n_err = 0;
    int         n;
    always #5 pclk = ~pclk;
    apb_req_issuer dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .transfer(transfer), .read_write(read_write),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
        .penable(penable), .pready(pready)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic push(input logic w, input logic [8:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge pclk);
        req_valid = 1'b0;
    endtask
    task automatic wait_xfer(output int cnt);
        cnt = 0;
        while (!transfer && cnt < 40) begin
            @(negedge pclk);
            cnt++;
        end
        check("xfer_seen", transfer, 1);
    endtask
    task automatic finish_xfer;
        penable = 1'b1;
        @(negedge pclk);
        pready = 1'b1;
        @(negedge pclk);
        penable = 1'b0;
        pready  = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge pclk);
        check("rst_transfer", transfer, 0);
        check("rst_read_write", read_write, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_wpaddr", apb_write_paddr, 0);
        check("rst_rpaddr", apb_read_paddr, 0);
        check("rst_rsp_err", rsp_err, 0);
        preset = 1'b0;
        @(negedge pclk);
        check("ready_after_rst", req_ready, 1);
        // single write
        push(1'b1, 9'h005, 8'hA5);
        check("wr_not_early", transfer, 0);
        @(negedge pclk);
        check("wr_transfer", transfer, 1);
        check("wr_read_write", read_write, 0);
        check("wr_wpaddr", apb_write_paddr, 9'h005);
        check("wr_wdata", apb_write_data, 8'hA5);
        check("wr_rpaddr", apb_read_paddr, 0);
        penable = 1'b1;
        @(negedge pclk);
        check("wr_wait_hold", transfer, 1);
        check("wr_wait_addr", apb_write_paddr, 9'h005);
        pready = 1'b1;
        @(negedge pclk);
        penable = 1'b0;
        pready  = 1'b0;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_write", rsp_write, 1);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_xfer_drop", transfer, 0);
        @(negedge pclk);
        check("wr_rsp_pulse", rsp_valid, 0);
        check("wr_idle_addr", apb_write_paddr, 0);
        // single read, data valid RD_LAT cycles after completion
        push(1'b0, 9'h105, 8'h00);
        wait_xfer(n);
        check("rd_issue_delay", n, 1);
        check("rd_read_write", read_write, 1);
        check("rd_rpaddr", apb_read_paddr, 9'h105);
        check("rd_wpaddr", apb_write_paddr, 0);
        check("rd_wdata", apb_write_data, 0);
        finish_xfer;
        apb_read_data_out = 8'hEE;
        check("rd_rsp_c1", rsp_valid, 0);
        @(negedge pclk);
        check("rd_rsp_c2", rsp_valid, 0);
        apb_read_data_out = 8'h3C;
        @(negedge pclk);
        apb_read_data_out = 8'h77;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 8'h3C);
        check("rd_rsp_write", rsp_write, 0);
        @(negedge pclk);
        check("rd_rsp_pulse", rsp_valid, 0);
        check("rd_rdata_hold", rsp_rdata, 8'h3C);
        // fill the FIFO with no completions; fifth request must be refused
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 9'h0A0 + 9'(i);
            req_wdata = 8'h50 + 8'(i);
            check("fill_ready", req_ready, i < 4);
            @(negedge pclk);
        end
        req_valid = 1'b0;
        check("full_ready", req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            wait_xfer(n);
            if (k > 0) check("fill_gap", n, 2);
            check("fill_addr", apb_write_paddr, 9'h0A0 + 9'(k));
            check("fill_data", apb_write_data, 8'h50 + 8'(k));
            finish_xfer;
            check("fill_rsp", rsp_valid, 1);
        end
        @(negedge pclk);
        check("drain_ready", req_ready, 1);
        // async reset while a read sits in WAIT
        push(1'b0, 9'h1AA, 8'h00);
        wait_xfer(n);
        @(negedge pclk);
        check("pre_rst_xfer", transfer, 1);
        #2 preset = 1'b1;
        #1;
        check("arst_transfer", transfer, 0);
        check("arst_read_write", read_write, 0);
        check("arst_rpaddr", apb_read_paddr, 0);
        check("arst_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("arst_no_rsp", rsp_valid, 0);
        end
        preset = 1'b0;
        @(negedge pclk);
        check("arst_ready_rel", req_ready, 1);
        repeat (3) @(negedge pclk);
        check("arst_flushed", transfer, 0);
        check("arst_no_rsp_rel", rsp_valid, 0);
        // push and completion pop in the same cycle at count=3
        push(1'b1, 9'h0B0, 8'h60);
        push(1'b1, 9'h0B1, 8'h61);
        push(1'b1, 9'h0B2, 8'h62);
        wait_xfer(n);
        check("sim_head", apb_write_paddr, 9'h0B0);
        penable = 1'b1;
        @(negedge pclk);
        pready    = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h0B3;
        req_wdata = 8'h63;
        check("sim_ready_before", req_ready, 1);
        @(negedge pclk);
        penable   = 1'b0;
        pready    = 1'b0;
        req_valid = 1'b0;
        check("sim_rsp", rsp_valid, 1);
        check("sim_ready_after", req_ready, 1);
        for (int k = 1; k < 4; k++) begin
            wait_xfer(n);
            check("sim_gap", n, 2);
            check("sim_addr", apb_write_paddr, 9'h0B0 + 9'(k));
            finish_xfer;
            check("sim_rsp_k", rsp_valid, 1);
        end
        @(negedge pclk);
        check("sim_drain_ready", req_ready, 1);
`ifdef APB_ISSUE_TIMEOUT_EN
        // no pready: ISSUE cycle plus 16 WAIT cycles with transfer high, then an error response
        push(1'b0, 9'h0C0, 8'h00);
        push(1'b1, 9'h0C1, 8'h71);
        wait_xfer(n);
        n = 0;
        while (transfer && n < 40) begin
            @(negedge pclk);
            n++;
        end
        check("tmo_xfer_cycles", n, 17);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
        wait_xfer(n);
        check("tmo_next_addr", apb_write_paddr, 9'h0C1);
        finish_xfer;
        check("tmo_next_rsp", rsp_valid, 1);
        check("tmo_next_err", rsp_err, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
